// File: rtl/fifo_burst_reader_if.sv
// Bundle of command, rotating-FIFO read/rotate and output-stream signals for fifo_burst_reader.
// The master modport is the burst reader; the slave modport is the surrounding FIFO/consumer side.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_offset;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_data_count;
  logic                  fifo_rotate_en;
  logic [ADDR_WIDTH-1:0] fifo_rotate_amount;
  logic                  fifo_rotate_direction;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  done;
  logic                  err;

  modport master (
    input  cmd_valid, cmd_offset, cmd_len, fifo_rd_data, fifo_empty, fifo_data_count, m_ready,
    output cmd_ready, fifo_rd_en, fifo_rotate_en, fifo_rotate_amount, fifo_rotate_direction,
           m_valid, m_data, m_last, done, err
  );

  modport slave (
    output cmd_valid, cmd_offset, cmd_len, fifo_rd_data, fifo_empty, fifo_data_count, m_ready,
    input  cmd_ready, fifo_rd_en, fifo_rotate_en, fifo_rotate_amount, fifo_rotate_direction,
           m_valid, m_data, m_last, done, err
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read engine for the rotating register FIFO: one left-rotate to the requested offset,
// then pops cmd_len items through a 2-entry output buffer onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, ROTATE, SETTLE, BURST, DRAIN, FINISH} state_t;

  state_t                     state;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [1:0][DATA_WIDTH-1:0] buf_data;
  logic [1:0]                 buf_last;
  logic [1:0]                 buf_cnt;
  logic                       cmd_ready_q, rot_en_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0]      rot_amt_q;
  logic                       pop, push;

  // Head of the FIFO is fall-through, so the pop decision is combinational and a
  // same-cycle consumer pop frees a slot, keeping 1 item/cycle throughput.
  assign pop  = (buf_cnt != 2'd0) && bus.m_ready;
  assign push = (state == BURST) && !bus.fifo_empty && (remaining != '0) &&
                ((buf_cnt != 2'd2) || pop);

  assign bus.fifo_rd_en            = push;
  assign bus.fifo_rotate_en        = rot_en_q;
  assign bus.fifo_rotate_amount    = rot_amt_q;
  assign bus.fifo_rotate_direction = 1'b0;
  assign bus.cmd_ready             = cmd_ready_q;
  assign bus.m_valid               = (buf_cnt != 2'd0);
  assign bus.m_data                = buf_data[0];
  assign bus.m_last                = buf_last[0];
  assign bus.done                  = done_q;
  assign bus.err                   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      cmd_ready_q <= 1'b1;
      rot_en_q    <= 1'b0;
      rot_amt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      buf_data    <= '0;
      buf_last    <= '0;
      buf_cnt     <= 2'd0;
    end else begin
      rot_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          remaining   <= bus.cmd_len;
          cmd_ready_q <= 1'b0;
          if (bus.cmd_len == '0) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end else if (bus.cmd_offset == '0) begin
            state <= BURST;
          end else if ({1'b0, bus.cmd_offset} >= bus.fifo_data_count) begin
            // Offset points past the occupied entries: reject without touching the FIFO.
            state  <= FINISH;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state     <= ROTATE;
            rot_en_q  <= 1'b1;
            rot_amt_q <= bus.cmd_offset;
          end
        end
        ROTATE: state <= SETTLE;
        SETTLE: state <= BURST;
        BURST: if (push) begin
          remaining <= remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: if (buf_cnt == 2'd0 || (pop && buf_cnt == 2'd1)) begin
          state  <= FINISH;
          done_q <= 1'b1;
        end
        FINISH: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Output buffer kept head-aligned: entry 0 is always the beat on m_data.
      case ({push, pop})
        2'b10: begin
          buf_data[buf_cnt[0]] <= bus.fifo_rd_data;
          buf_last[buf_cnt[0]] <= (remaining == LEN_WIDTH'(1));
          buf_cnt              <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_data[0] <= bus.fifo_rd_data;
            buf_last[0] <= (remaining == LEN_WIDTH'(1));
          end else begin
            buf_data[0] <= buf_data[1];
            buf_last[0] <= buf_last[1];
            buf_data[1] <= bus.fifo_rd_data;
            buf_last[1] <= (remaining == LEN_WIDTH'(1));
          end
        end
        default: ;
      endcase
    end
  end
endmodule
